// File: rtl/quantize_seq.sv
`default_nettype none
// ============================================================================
// Module      : quantize_seq
// Description : Sequential complex-sample quantizer. It divides both
//               components by a runtime divisor using a restoring
//               shift-subtract divider. A zero divisor saturates the result.
//               Optional macro QUANTIZE_ROUND_EN rounds to nearest, with
//               ties away from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module quantize_seq #(
    parameter int W  = 8,
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic [2*W-1:0]  in_data,
    input  logic [DW-1:0]   in_div,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*W-1:0]  out_data,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int                 c_CNT_W   = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(W - 1);
    localparam logic [W-1:0]       c_SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]       c_SAT_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run;
    logic [W-1:0]        r_q_re;
    logic [W-1:0]        r_q_im;
    logic [DW-1:0]       r_rem_re;
    logic [DW-1:0]       r_rem_im;
    logic [DW-1:0]       r_div;
    logic                r_neg_re;
    logic                r_neg_im;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*W-1:0]      r_out;
    logic                r_err;

    logic [W-1:0]        w_in_re;
    logic [W-1:0]        w_in_im;
    logic [W-1:0]        w_mag_re;
    logic [W-1:0]        w_mag_im;
    logic                w_accept;
    logic [W+DW-1:0]     w_step_re;
    logic [W+DW-1:0]     w_step_im;
    logic [W-1:0]        w_qn_re;
    logic [W-1:0]        w_qn_im;
    logic [DW-1:0]       w_rn_re;
    logic [DW-1:0]       w_rn_im;
    logic                w_rnd_re;
    logic                w_rnd_im;

    // The dividend shifts out of the MSB while quotient bits shift into the LSB.
    function automatic logic [W+DW-1:0] div_step(input logic [W-1:0]  q,
                                                 input logic [DW-1:0] rem,
                                                 input logic [DW-1:0] d);
        logic [DW:0] trial;
        logic        bit_q;
        trial = {rem, q[W-1]};
        bit_q = (trial >= {1'b0, d});
        if (bit_q)
            trial = trial - {1'b0, d};
        return {q[W-2:0], bit_q, trial[DW-1:0]};
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag,
                                                input logic         rnd,
                                                input logic         neg);
        logic [W-1:0] m;
        m = mag + {{(W-1){1'b0}}, rnd};
        return neg ? (~m + 1'b1) : m;
    endfunction

    assign w_in_re   = in_data[2*W-1:W];
    assign w_in_im   = in_data[W-1:0];
    assign w_mag_re  = w_in_re[W-1] ? (~w_in_re + 1'b1) : w_in_re;
    assign w_mag_im  = w_in_im[W-1] ? (~w_in_im + 1'b1) : w_in_im;

    assign in_ready  = r_run & ~clear & (r_state == IDLE);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out;
    assign out_err   = r_err;

    assign w_step_re = div_step(r_q_re, r_rem_re, r_div);
    assign w_step_im = div_step(r_q_im, r_rem_im, r_div);
    assign w_qn_re   = w_step_re[W+DW-1:DW];
    assign w_qn_im   = w_step_im[W+DW-1:DW];
    assign w_rn_re   = w_step_re[DW-1:0];
    assign w_rn_im   = w_step_im[DW-1:0];

`ifdef QUANTIZE_ROUND_EN
    assign w_rnd_re  = ({w_rn_re, 1'b0} >= {1'b0, r_div});
    assign w_rnd_im  = ({w_rn_im, 1'b0} >= {1'b0, r_div});
`else
    assign w_rnd_re  = 1'b0;
    assign w_rnd_im  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = (in_div == '0) ? DONE : DIV;
                DIV:     if (r_cnt == c_LAST) w_state_nxt = DONE;
                DONE:    if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // r_run holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_q_re   <= '0;
            r_q_im   <= '0;
            r_rem_re <= '0;
            r_rem_im <= '0;
            r_div    <= '0;
            r_neg_re <= 1'b0;
            r_neg_im <= 1'b0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (!clear) begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_q_re   <= w_mag_re;
                            r_q_im   <= w_mag_im;
                            r_rem_re <= '0;
                            r_rem_im <= '0;
                            r_div    <= in_div;
                            r_neg_re <= w_in_re[W-1];
                            r_neg_im <= w_in_im[W-1];
                            r_cnt    <= '0;
                            if (in_div == '0) begin
                                r_out <= {w_in_re[W-1] ? c_SAT_NEG : c_SAT_POS,
                                          w_in_im[W-1] ? c_SAT_NEG : c_SAT_POS};
                                r_err <= 1'b1;
                            end
                        end
                    end
                    DIV: begin
                        r_q_re   <= w_qn_re;
                        r_q_im   <= w_qn_im;
                        r_rem_re <= w_rn_re;
                        r_rem_im <= w_rn_im;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_out <= {apply_sign(w_qn_re, w_rnd_re, r_neg_re),
                                      apply_sign(w_qn_im, w_rnd_im, r_neg_im)};
                            r_err <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quantize_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_quantize_seq
// Description : Self-checking bench for quantize_seq. It runs directed cases
//               and randomized samples against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quantize_seq;
    localparam int W  = 8;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic [2*W-1:0]  in_data;
    logic [DW-1:0]   in_div;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  out_data;
    logic            out_err;
    logic            out_valid;
    logic            out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    quantize_seq #(.W(W), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_div    (in_div),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: signed integer arithmetic on one component.
    function automatic logic [7:0] ref_comp(input logic [7:0] x, input logic [3:0] d);
        int v, m, q, r, dd;
        logic [31:0] qv;
        v  = $signed(x);
        dd = int'(d);
        if (dd == 0)
            return (v < 0) ? 8'h80 : 8'h7F;
        m = (v < 0) ? -v : v;
        q = m / dd;
        r = m % dd;
`ifdef QUANTIZE_ROUND_EN
        if (2 * r >= dd)
            q = q + 1;
`endif
        if (v < 0)
            q = -q;
        qv = q;
        return qv[7:0];
    endfunction

    function automatic logic [15:0] ref_data(input logic [15:0] x, input logic [3:0] d);
        return {ref_comp(x[15:8], d), ref_comp(x[7:0], d)};
    endfunction

    task automatic accept_only(input logic [15:0] data, input logic [3:0] d);
        int n;
        @(negedge clk);
        in_data  = data;
        in_div   = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_div   = 4'($urandom);
    endtask

    task automatic run_txn(input logic [15:0] data, input logic [3:0] d,
                           input logic [15:0] exp_data, input logic exp_err,
                           input int exp_lat, input int hold, input logic hold_valid);
        int lat;
        logic [15:0] seen;
        accept_only(data, d);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("out_data", 32'(out_data), 32'(exp_data));
        check("out_err", 32'(out_err), 32'(exp_err));
        seen = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = hold_valid;
            in_data  = 16'($urandom);
            in_div   = 4'($urandom);
            check("stall_rdy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("stall_vld", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(seen));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("consume", 32'(out_valid), 32'd0);
        check("rdy_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] x;
        logic [3:0]  d;
        logic        seen_valid;

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_div    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 32'(in_ready), 32'd1);

        run_txn(16'h1EF1, 4'd3, 16'h0AFB, 1'b0, W + 1, 0, 1'b0);
`ifdef QUANTIZE_ROUND_EN
        run_txn(16'h8008, 4'd3, 16'hD503, 1'b0, W + 1, 0, 1'b0);
`else
        run_txn(16'h8008, 4'd3, 16'hD602, 1'b0, W + 1, 0, 1'b0);
`endif
        run_txn(16'h7F80, 4'd0, 16'h7F80, 1'b1, 1, 0, 1'b0);
        run_txn(16'h8080, 4'd1, 16'h8080, 1'b0, W + 1, 0, 1'b0);
        run_txn(16'h1EF1, 4'd3, 16'h0AFB, 1'b0, W + 1, 5, 1'b1);

        // Soft clear in the fourth division cycle discards the sample.
        accept_only(16'h1EF1, 4'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        check("clear_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("clear_drop", 32'(seen_valid), 32'd0);
        run_txn(16'h0906, 4'd3, 16'h0302, 1'b0, W + 1, 0, 1'b0);

        // Asynchronous reset in the third division cycle.
        accept_only(16'h1EF1, 4'd3);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_rel", 32'(in_ready), 32'd1);
`ifdef QUANTIZE_ROUND_EN
        run_txn(16'hF7F7, 4'd2, 16'hFBFB, 1'b0, W + 1, 0, 1'b0);
`else
        run_txn(16'hF7F7, 4'd2, 16'hFCFC, 1'b0, W + 1, 0, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            x = 16'($urandom);
            d = (t % 6 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            run_txn(x, d, ref_data(x, d), (d == 4'd0), (d == 4'd0) ? 1 : W + 1,
                    int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quantize_seq.md
QUANTIZE_SEQ -- requirements
Module: quantize_seq

Interface
REQ-001 Parameter W, default 8: bit width of each component (real, imaginary); the packed sample is 2*W bits.
REQ-002 Parameter DW, default 4: bit width of the unsigned runtime divisor.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous soft clear, active-high.
REQ-006 in_data  input  2*W  packed sample {re[2W-1:W], im[W-1:0]}, each two's complement.
REQ-007 in_div  input  DW  unsigned divisor; sampled together with in_data.
REQ-008 in_valid  input  1  in_data and in_div are valid.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_data  output  2*W  packed quantized sample {q_re, q_im}.
REQ-011 out_err  output  1  result came from a zero divisor; qualified by out_valid.
REQ-012 out_valid  output  1  out_data and out_err are valid.
REQ-013 out_ready  input  1  downstream consumes the result.

Function
REQ-014 The block SHALL compute per component q = sign(x)*(|x| div d), truncating toward zero (sign-magnitude division), with |x| held as an unsigned W-bit value so that x = -2^(W-1) gives magnitude 2^(W-1).
REQ-015 The FSM SHALL have the states IDLE, DIV and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with clear=0; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-017 On a transfer, the block SHALL register both magnitudes, both signs and the divisor. It SHALL go to DIV if d!=0, else to DONE.
REQ-018 DIV SHALL run a restoring shift-subtract division on both components in parallel, one quotient bit per cycle, for exactly W cycles, then go to DONE.
REQ-019 Latency SHALL be W+1 cycles from the accepting edge to out_valid=1 when d!=0, and 1 cycle when d=0; throughput is one sample per W+2 cycles at minimum.
REQ-020 out_valid SHALL be 1 only in DONE. out_data and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A DONE-state edge with out_ready=1 SHALL return the FSM to IDLE; no new sample is accepted on that same edge.
REQ-022 When d=0, each component SHALL saturate to 2^(W-1)-1 if x>=0, else to -2^(W-1), and out_err SHALL be 1; otherwise out_err SHALL be 0.
REQ-023 The negation of a quotient magnitude SHALL be taken modulo 2^W; the magnitude is <=2^(W-1), so no overflow occurs.
REQ-024 clear=1 SHALL force IDLE on the next edge from any state, discard any in-flight or unconsumed result, and block acceptance; clear has priority over every transfer.
REQ-025 Changes on in_data and in_div outside a transfer SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_err=0, out_data=0 and all internal registers to 0.
REQ-027 Assertion of rst_n mid-division SHALL abandon the operation. After release, the first accepted sample SHALL follow REQ-019 exactly.
REQ-028 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 from the first edge after release, provided clear=0.

Configuration
REQ-029 Macro QUANTIZE_ROUND_EN: when defined, each nonzero-divisor result SHALL be rounded to nearest with ties away from zero (magnitude+1 when 2*remainder>=d, using a one-cycle-free compare on the final remainder, with no extra latency).
REQ-030 When QUANTIZE_ROUND_EN is undefined, results SHALL truncate toward zero per REQ-014. The d=0 behaviour is identical in both builds.

Verification (W=8, DW=4)
REQ-031 in_data=0x1EF1, d=3 -> out_data=0x0AFB (10, -5), out_err=0, out_valid rises 9 cycles after the accept.
REQ-032 in_data=0x8008, d=3 -> truncate build 0xD602 (-42, 2); round build 0xD503 (-43, 3).
REQ-033 in_data=0x7F80, d=0 -> out_data=0x7F80, out_err=1, out_valid rises 1 cycle after the accept.
REQ-034 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> out_data stable, in_ready=0, no second accept; out_ready=1 -> IDLE, next sample accepted on the following edge.
REQ-035 clear=1 at DIV cycle 4 -> no out_valid for that sample; the next sample 0x0906/d=3 gives 0x0302.
REQ-036 rst_n pulsed low at DIV cycle 3 -> outputs 0 immediately; the post-reset sample 0xF7F7/d=2 gives 0xFCFC in the truncate build and 0xFBFB in the round build.
